tx_framing_ctrl: RTL
====================

# tx_framing_ctrl

Transmit framing controller that sits directly upstream of the forced-control symbol mux. It takes a byte-wide packet stream with a valid/ready handshake. Each cycle it drives the mux selector `CONTROL` and the data byte `TX_BUFFER`, producing `IDL` between packets, `STP`/data/`END` framing around packets, `EDB` on underrun, and periodic `COM`+`SKP` ordered sets at packet boundaries.

## Interface
- `SKP_INTERVAL`, 1180: cycles between SKP ordered-set requests; range 16..65535.
- `SKP_COUNT`, 3: number of `SKP` symbols following each `COM`; range 1..4.
- `CLK` in 1: single clock; all logic on posedge.
- `RESET_L` in 1: reset, asynchronous and active-low.
- `DATA_IN` in 8: packet byte.
- `DATA_VALID` in 1: `DATA_IN` holds a valid byte.
- `DATA_LAST` in 1: the current byte is the final byte of the packet; qualified by `DATA_VALID`.
- `DATA_READY` out 1: the controller accepts a byte this cycle.
- `CONTROL` out 4: mux selector: 0 COM, 1 PAD, 2 SKP, 3 STP, 4 SDP, 5 END, 6 EDB, 7 FTS, 8 IDL, 9 DATA.
- `TX_BUFFER` out 8: data byte; meaningful only when `CONTROL`=9.
- `ABORT_CNT` out 8: saturating count of aborted (underrun) packets.

## Operation
- States: IDLE, SKP_COM, SKP_SYM, DATA, END_S, DRAIN.
- `DATA_READY` is decoded from state only: it is 1 in DATA and DRAIN, and 0 otherwise. A transfer is `DATA_VALID & DATA_READY` sampled at posedge.
- IDLE:
  - `skp_pending` → load `CONTROL`=COM, clear pending, go to SKP_COM.
  - Otherwise, `DATA_VALID` → load `CONTROL`=STP, go to DATA. This does not consume a byte.
  - Otherwise, load `CONTROL`=IDL.
- SKP_COM/SKP_SYM: emit `SKP` exactly `SKP_COUNT` times (internal 3-bit counter), then return to IDLE.
- DATA, transfer occurs: load `CONTROL`=9 and `TX_BUFFER`=`DATA_IN`.
  - `DATA_LAST`=1 → go to END_S.
  - Otherwise stay in DATA.
- DATA, `DATA_VALID`=0 (underrun): load `CONTROL`=EDB, increment `ABORT_CNT` (saturates at 255), go to DRAIN.
- DRAIN: load `CONTROL`=IDL and discard accepted bytes. A transfer with `DATA_LAST`=1 → go to IDLE.
- END_S: load `CONTROL`=END, go to IDLE.
- SKP timer:
  - Free-running 16-bit counter, counts 0..`SKP_INTERVAL`-1 then wraps.
  - On wrap it sets `skp_pending`. A wrap while pending is already set is absorbed; requests do not stack.
  - Timer and pending flag run in every state.
  - A pending SKP is serviced only from IDLE, so it never interrupts a packet, DRAIN or an ordered set.
- Simultaneous `skp_pending` and `DATA_VALID` in IDLE: SKP wins, and the packet starts after the ordered set.
- Back-to-back packets are legal: END may be followed immediately by STP.
- A zero-length packet is impossible: the first byte after STP is always data, or EDB if it is absent.
- `TX_BUFFER` holds its last value when `CONTROL`≠9.

## Timing
- Reset values (asynchronous, while `RESET_L`=0):
  - `CONTROL`=8 (IDL), `TX_BUFFER`=0, `DATA_READY`=0, `ABORT_CNT`=0.
  - State IDLE, timer 0, `skp_pending`=0.
- First `skp_pending` is set `SKP_INTERVAL` cycles after reset release.
- `CONTROL`/`TX_BUFFER` are registered with 1-cycle latency: a byte transferred at edge k appears on `TX_BUFFER` after edge k.
- Minimum packet of N bytes occupies N+2 output cycles (STP, N×DATA, END), with STP one cycle after `DATA_VALID` is first seen in IDLE.
- Ordered set occupies 1+`SKP_COUNT` consecutive output cycles.
- Reset mid-packet: outputs return to reset values immediately. No END or EDB is emitted; upstream must flush its own state.
- Throughput: one byte per cycle in DATA with no bubbles while `DATA_VALID` stays high.

## Structure
- Shared define file holds the control-code constants (COM..IDL and DATA=9) shared with the symbol mux, plus the state encodings.
- Natural sub-module: `skp_interval_timer` (counter plus `skp_pending` flag, with parameter `SKP_INTERVAL`, input clear, output pending).

## Test plan
- Reset release, no traffic, `SKP_INTERVAL`=32, `SKP_COUNT`=3 → `CONTROL`=8 continuously. At cycle 32 after release the sequence is 0,2,2,2, then back to 8.
- 4-byte packet A1,B2,C3,D4 with `DATA_LAST` on D4 → `CONTROL` 3,9,9,9,9,5. `TX_BUFFER` shows A1..D4 on the four DATA cycles. `DATA_READY` is high for exactly 4 transfers.
- `DATA_VALID` dropped after 2 of 5 bytes → `CONTROL` 3,9,9,6. DRAIN accepts the remaining 3 bytes with `CONTROL`=8. `ABORT_CNT`=1.
- SKP expiry during a 10-byte packet → packet uninterrupted through END, then 0,2,2,2 before any new STP.
- Two back-to-back 1-byte packets (55, 66) → `CONTROL` 3,9,5,3,9,5 with `TX_BUFFER`=55 then 66.
- 256 forced underruns → `ABORT_CNT` saturates at 255. Reset asserted mid-packet → `CONTROL`=8 and `DATA_READY`=0 immediately.

Source files
------------

// File: rtl/tx_framing_ctrl_pkg.sv
// Control-code constants shared with the downstream symbol mux, plus the
// framing FSM state encoding and a small saturating-increment helper.
package tx_framing_ctrl_pkg;

    localparam logic [3:0] CTL_COM  = 4'd0;
    localparam logic [3:0] CTL_PAD  = 4'd1;
    localparam logic [3:0] CTL_SKP  = 4'd2;
    localparam logic [3:0] CTL_STP  = 4'd3;
    localparam logic [3:0] CTL_SDP  = 4'd4;
    localparam logic [3:0] CTL_END  = 4'd5;
    localparam logic [3:0] CTL_EDB  = 4'd6;
    localparam logic [3:0] CTL_FTS  = 4'd7;
    localparam logic [3:0] CTL_IDL  = 4'd8;
    localparam logic [3:0] CTL_DATA = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SKP_COM = 3'd1,
        ST_SKP_SYM = 3'd2,
        ST_DATA    = 3'd3,
        ST_END     = 3'd4,
        ST_DRAIN   = 3'd5
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/tx_framing_ctrl_skp.sv
// Free-running SKP interval timer; raises a sticky request on every wrap.
// Wraps while a request is outstanding are absorbed rather than queued.
module skp_interval_timer
    import tx_framing_ctrl_pkg::*;
#(
    parameter int SKP_INTERVAL = 1180
) (
    input  logic CLK,
    input  logic RESET_L,
    input  logic clear,
    output logic pending
);

    localparam logic [15:0] LAST = 16'(SKP_INTERVAL - 1);

    logic [15:0] count;
    logic        wrap;

    assign wrap = (count == LAST);

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            count   <= 16'd0;
            pending <= 1'b0;
        end else begin
            count <= wrap ? 16'd0 : count + 16'd1;
            // A wrap landing on the service cycle is treated as absorbed.
            if (clear)
                pending <= 1'b0;
            else if (wrap)
                pending <= 1'b1;
        end
    end

endmodule

// File: rtl/tx_framing_ctrl.sv
// Transmit framing controller: wraps a byte stream in STP/DATA/END, flags
// underruns with EDB, and inserts COM+SKP ordered sets between packets.
module tx_framing_ctrl
    import tx_framing_ctrl_pkg::*;
#(
    parameter int SKP_INTERVAL = 1180,
    parameter int SKP_COUNT    = 3
) (
    input  logic       CLK,
    input  logic       RESET_L,
    input  logic [7:0] DATA_IN,
    input  logic       DATA_VALID,
    input  logic       DATA_LAST,
    output logic       DATA_READY,
    output logic [3:0] CONTROL,
    output logic [7:0] TX_BUFFER,
    output logic [7:0] ABORT_CNT,
    output logic [2:0] FSM_STATE
);

    localparam logic [2:0] SKP_LAST = 3'(SKP_COUNT);

    state_t     state, state_nx;
    logic [3:0] control_nx;
    logic [7:0] tx_nx;
    logic [7:0] abort_nx;
    logic [2:0] skp_cnt, skp_cnt_nx;
    logic       skp_pending, skp_clear, xfer;

    skp_interval_timer #(.SKP_INTERVAL(SKP_INTERVAL)) u_skp (
        .CLK     (CLK),
        .RESET_L (RESET_L),
        .clear   (skp_clear),
        .pending (skp_pending)
    );

    // Handshake: a byte moves on any posedge where DATA_VALID & DATA_READY;
    // DATA_READY is a pure state decode and never looks at DATA_VALID.
    assign DATA_READY = (state == ST_DATA) || (state == ST_DRAIN);
    assign xfer       = DATA_VALID & DATA_READY;
    assign FSM_STATE  = state;

    always_comb begin
        state_nx   = state;
        control_nx = CONTROL;
        tx_nx      = TX_BUFFER;
        abort_nx   = ABORT_CNT;
        skp_cnt_nx = skp_cnt;
        skp_clear  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (skp_pending) begin
                    control_nx = CTL_COM;
                    skp_clear  = 1'b1;
                    state_nx   = ST_SKP_COM;
                end else if (DATA_VALID) begin
                    control_nx = CTL_STP;
                    state_nx   = ST_DATA;
                end else begin
                    control_nx = CTL_IDL;
                end
            end
            ST_SKP_COM: begin
                control_nx = CTL_SKP;
                skp_cnt_nx = 3'd1;
                state_nx   = ST_SKP_SYM;
            end
            ST_SKP_SYM: begin
                if (skp_cnt == SKP_LAST) begin
                    control_nx = CTL_IDL;
                    state_nx   = ST_IDLE;
                end else begin
                    control_nx = CTL_SKP;
                    skp_cnt_nx = skp_cnt + 3'd1;
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    control_nx = CTL_DATA;
                    tx_nx      = DATA_IN;
                    if (DATA_LAST)
                        state_nx = ST_END;
                end else begin
                    control_nx = CTL_EDB;
                    abort_nx   = sat_inc8(ABORT_CNT);
                    state_nx   = ST_DRAIN;
                end
            end
            ST_END: begin
                control_nx = CTL_END;
                state_nx   = ST_IDLE;
            end
            ST_DRAIN: begin
                // Remainder of an aborted packet is swallowed silently.
                control_nx = CTL_IDL;
                if (xfer && DATA_LAST)
                    state_nx = ST_IDLE;
            end
            default: begin
                control_nx = CTL_IDL;
                state_nx   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state     <= ST_IDLE;
            CONTROL   <= CTL_IDL;
            TX_BUFFER <= 8'd0;
            ABORT_CNT <= 8'd0;
            skp_cnt   <= 3'd0;
        end else begin
            state     <= state_nx;
            CONTROL   <= control_nx;
            TX_BUFFER <= tx_nx;
            ABORT_CNT <= abort_nx;
            skp_cnt   <= skp_cnt_nx;
        end
    end

endmodule
